// File: rtl/dqs_wseq_pkg.sv
// Shared types and nibble constants for the DQS write sequencer.
// Optional feature macro: DQS_WSEQ_SEAMLESS_EN (back-to-back bursts without POST/PRE gap).
package dqs_wseq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    BURST   = 3'd2,
    POST    = 3'd3,
    DLY_LD  = 3'd4,
    DLY_SET = 3'd5
  } state_e;

  // Nibbles are bit0-first in time; each nibble covers two memory clocks.
  localparam logic [3:0] NIB_IDLE_D  = 4'b0000;
  localparam logic [3:0] NIB_IDLE_T  = 4'b1111;
  localparam logic [3:0] NIB_PRE_D   = 4'b0000;
  localparam logic [3:0] NIB_PRE_T   = 4'b0011;
  localparam logic [3:0] NIB_BURST_D = 4'b0101;
  localparam logic [3:0] NIB_BURST_T = 4'b0000;
  localparam logic [3:0] NIB_POST_D  = 4'b0000;
  localparam logic [3:0] NIB_POST_T  = 4'b1100;

  function automatic logic [3:0] nib_data(input state_e s);
    case (s)
      PRE:     return NIB_PRE_D;
      BURST:   return NIB_BURST_D;
      POST:    return NIB_POST_D;
      default: return NIB_IDLE_D;
    endcase
  endfunction

  function automatic logic [3:0] nib_tri(input state_e s);
    case (s)
      PRE:     return NIB_PRE_T;
      BURST:   return NIB_BURST_T;
      POST:    return NIB_POST_T;
      default: return NIB_IDLE_T;
    endcase
  endfunction

endpackage

// File: rtl/dqs_wseq_if.sv
// Bus bundle between the write controller (master) and the DQS sequencer (slave).
// Handshake: a write request is taken on any rising edge where wr_start=1 and
// wr_ready=1 in the same cycle; wr_start with wr_ready=0 is dropped. dly_wr is a
// single-cycle strobe with no back-pressure; dly_pending reports a deferred load.
interface dqs_wseq_if #(
  parameter int LEN_BITS = 4,
  parameter int DLY_BITS = 8
);
  import dqs_wseq_pkg::*;

  logic                wr_start;
  logic [LEN_BITS-1:0] wr_len;
  logic                wr_ready;
  logic                busy;
  logic [3:0]          dqs_data;
  logic [3:0]          dqs_tri;
  logic                dly_wr;
  logic [1:0]          dly_sel;
  logic [DLY_BITS-1:0] dly_val;
  logic                dly_pending;
  logic [DLY_BITS-1:0] dly_out;
  logic                ld_dly_data;
  logic                ld_dly_tri;
  logic                dly_set;
  state_e              dbg_state;

  modport master (
    output wr_start, wr_len, dly_wr, dly_sel, dly_val,
    input  wr_ready, busy, dqs_data, dqs_tri, dly_pending, dly_out,
           ld_dly_data, ld_dly_tri, dly_set, dbg_state
  );

  modport slave (
    input  wr_start, wr_len, dly_wr, dly_sel, dly_val,
    output wr_ready, busy, dqs_data, dqs_tri, dly_pending, dly_out,
           ld_dly_data, ld_dly_tri, dly_set, dbg_state
  );

endinterface

// File: rtl/dqs_wseq_dly_loader.sv
// Odelay load helper: holds a deferred load while the sequencer is not idle and
// emits the ld pulses (per select bit) followed one cycle later by the set pulse.
module dqs_dly_loader #(
  parameter int DLY_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idle_i,
  input  logic                wr_start_i,
  input  logic                dly_wr_i,
  input  logic [1:0]          dly_sel_i,
  input  logic [DLY_BITS-1:0] dly_val_i,
  output logic                issue_o,
  output logic                pend_next_o,
  output logic                dly_pending_o,
  output logic [DLY_BITS-1:0] dly_out_o,
  output logic                ld_data_o,
  output logic                ld_tri_o,
  output logic                set_o
);

  logic                pend_q, pend_d;
  logic [1:0]          psel_q, psel_d;
  logic [DLY_BITS-1:0] pval_q, pval_d;
  logic [DLY_BITS-1:0] out_q, out_d;
  logic                ldd_q, ldd_d, ldt_q, ldt_d, set_q;
  logic                wr_new, issue_pend, issue_direct;
  logic [1:0]          iss_sel;

  // Decide between issuing a held load, issuing a fresh one, or latching it.
  // A fresh request arriving in the same cycle a held one issues is merged in.
  always_comb begin
    wr_new       = dly_wr_i && (dly_sel_i != 2'b00);
    issue_pend   = idle_i && pend_q;
    issue_direct = idle_i && !pend_q && wr_new && !wr_start_i;
    pend_d  = pend_q;
    psel_d  = psel_q;
    pval_d  = pval_q;
    out_d   = out_q;
    iss_sel = 2'b00;
    if (issue_pend) begin
      iss_sel = psel_q | (wr_new ? dly_sel_i : 2'b00);
      out_d   = wr_new ? dly_val_i : pval_q;
      pend_d  = 1'b0;
      psel_d  = 2'b00;
    end else if (issue_direct) begin
      iss_sel = dly_sel_i;
      out_d   = dly_val_i;
    end else if (wr_new) begin
      pend_d = 1'b1;
      psel_d = psel_q | dly_sel_i;
      pval_d = dly_val_i;
    end
    ldd_d = iss_sel[0];
    ldt_d = iss_sel[1];
  end

  // Pending latch, delay value register and pulse pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      psel_q <= 2'b00;
      pval_q <= '0;
      out_q  <= '0;
      ldd_q  <= 1'b0;
      ldt_q  <= 1'b0;
      set_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      psel_q <= psel_d;
      pval_q <= pval_d;
      out_q  <= out_d;
      ldd_q  <= ldd_d;
      ldt_q  <= ldt_d;
      set_q  <= ldd_q | ldt_q;
    end
  end

  assign issue_o       = issue_pend | issue_direct;
  assign pend_next_o   = pend_d;
  assign dly_pending_o = pend_q;
  assign dly_out_o     = out_q;
  assign ld_data_o     = ldd_q;
  assign ld_tri_o      = ldt_q;
  assign set_o         = set_q;

endmodule

// File: rtl/dqs_wseq.sv
// DQS write nibble sequencer (clk_div domain): preamble, BL8 toggle bursts,
// postamble, plus odelay load sequencing. Optional macro DQS_WSEQ_SEAMLESS_EN
// lets a new request be taken in the last burst cycle with no POST/PRE gap.
module dqs_wseq
  import dqs_wseq_pkg::*;
#(
  parameter int LEN_BITS = 4,
  parameter int DLY_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  dqs_wseq_if.slave  bus
);

  localparam int CNT_W = LEN_BITS + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d, busy_q, busy_d;
  logic [3:0]       data_q, tri_q;
  logic             accept, issue, pend_next, idle;

  assign idle   = (state_q == IDLE);
  assign accept = bus.wr_start && rdy_q;

  dqs_dly_loader #(.DLY_BITS(DLY_BITS)) u_loader (
    .clk          (clk),
    .rst          (rst),
    .idle_i       (idle),
    .wr_start_i   (bus.wr_start),
    .dly_wr_i     (bus.dly_wr),
    .dly_sel_i    (bus.dly_sel),
    .dly_val_i    (bus.dly_val),
    .issue_o      (issue),
    .pend_next_o  (pend_next),
    .dly_pending_o(bus.dly_pending),
    .dly_out_o    (bus.dly_out),
    .ld_data_o    (bus.ld_dly_data),
    .ld_tri_o     (bus.ld_dly_tri),
    .set_o        (bus.dly_set)
  );

  // Next state and burst counter; counter holds (burst cycles - 1) and
  // the last BURST cycle is the one where it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = DLY_LD;
        end else if (accept) begin
          state_d = PRE;
          cnt_d   = {bus.wr_len, 1'b1};
        end
      end
      PRE:   state_d = BURST;
      BURST: begin
        if (cnt_q == '0) begin
`ifdef DQS_WSEQ_SEAMLESS_EN
          if (accept) begin
            cnt_d = {bus.wr_len, 1'b1};
          end else begin
            state_d = POST;
          end
`else
          state_d = POST;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      POST:    state_d = IDLE;
      DLY_LD:  state_d = DLY_SET;
      DLY_SET: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE) && !pend_next;
`ifdef DQS_WSEQ_SEAMLESS_EN
    rdy_d = rdy_d || ((state_d == BURST) && (cnt_d == '0));
`endif
    busy_d = (state_d == PRE) || (state_d == BURST) || (state_d == POST);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      data_q  <= NIB_IDLE_D;
      tri_q   <= NIB_IDLE_T;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      data_q  <= nib_data(state_d);
      tri_q   <= nib_tri(state_d);
    end
  end

  assign bus.wr_ready  = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.dqs_data  = data_q;
  assign bus.dqs_tri   = tri_q;
  assign bus.dbg_state = state_q;

endmodule
